// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: front end for the 8x8 Robertson's signed multiplier.
// Operand pairs are queued in a small FIFO. Each job gets a one-cycle restart
// pulse to the multiplier, and the operands stay stable while it runs. The
// multiplier's done is ignored for MIN_WAIT cycles after launch. The product
// is then returned on a single-entry valid/ready result register.
// Optional feature macro: SEQ_TIMEOUT_EN. When it is defined, a watchdog
// turns a job that never completes into an error result.
module mult_job_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int MIN_WAIT       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_multiplier,
    input  logic [7:0]  in_multiplicand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_product,
    output logic        out_error,
    output logic        mult_rst,
    output logic [7:0]  mult_multiplier,
    output logic [7:0]  mult_multiplicand,
    input  logic        mult_done,
    input  logic [15:0] mult_product,
    output logic        busy
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int WCNT_MAX = (TIMEOUT_CYCLES > MIN_WAIT) ? TIMEOUT_CYCLES : MIN_WAIT;
    localparam int WCNT_W   = $clog2(WCNT_MAX + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_MIN_C = WCNT_W'(MIN_WAIT);
    localparam logic [WCNT_W-1:0] WCNT_SAT_C = WCNT_W'(WCNT_MAX);
`ifdef SEQ_TIMEOUT_EN
    localparam logic [WCNT_W-1:0] TIMEOUT_C  = WCNT_W'(TIMEOUT_CYCLES);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESULT
    } state_e;

    // FIFO storage and bookkeeping
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Sequencer state, operand hold and result registers
    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]        op_a_q, op_a_d;
    logic [7:0]        op_b_q, op_b_d;
    logic [15:0]       res_q, res_d;
    logic              mult_rst_q, mult_rst_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_product_q, out_product_d;
`ifdef SEQ_TIMEOUT_EN
    logic              err_q, err_d;
    logic              out_error_q, out_error_d;
`endif

    // The ready flag depends on the count only, so a push into a full FIFO is
    // refused even when a pop happens in the same cycle.
    assign in_ready = (count_q != DEPTH_C);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);

    // FIFO pointer and occupancy update; the pointers wrap because the depth is a power of two
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO payload write; the stored entries are never read unless the count qualifies them
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the reset pointers and count already mark it empty.
        if (push) mem_q[wr_ptr_q] <= {in_multiplier, in_multiplicand};
    end

    // Next-state logic for the job FSM and the result register
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        res_d         = res_q;
        mult_rst_d    = 1'b0;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
`ifdef SEQ_TIMEOUT_EN
        err_d         = err_q;
        out_error_d   = out_error_q;
`endif

        // The consumer drains the result register; the RESULT state may refill it below.
        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    op_a_d     = mem_q[rd_ptr_q][15:8];
                    op_b_d     = mem_q[rd_ptr_q][7:0];
                    mult_rst_d = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q != WCNT_SAT_C) wcnt_d = wcnt_q + WCNT_W'(1);
                // The multiplier's done is a level that survives its restart.
                // A done seen during the blanking window belongs to the
                // previous job, so it is ignored.
                if (mult_done && (wcnt_q >= WAIT_MIN_C)) begin
                    res_d   = mult_product;
`ifdef SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESULT;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wcnt_q >= TIMEOUT_C) begin
                    res_d   = 16'h0000;
                    err_d   = 1'b1;
                    state_d = S_RESULT;
                end
`endif
            end
            S_RESULT: begin
                if (!out_valid_q || out_ready) begin
                    out_valid_d   = 1'b1;
                    out_product_d = res_q;
`ifdef SEQ_TIMEOUT_EN
                    out_error_d   = err_q;
`endif
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards queued jobs, the in-flight job and any pending result
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            wcnt_q        <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            res_q         <= '0;
            mult_rst_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
`ifdef SEQ_TIMEOUT_EN
            err_q         <= 1'b0;
            out_error_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            res_q         <= res_d;
            mult_rst_q    <= mult_rst_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
`ifdef SEQ_TIMEOUT_EN
            err_q         <= err_d;
            out_error_q   <= out_error_d;
`endif
        end
    end

    assign mult_rst          = mult_rst_q;
    assign mult_multiplier   = op_a_q;
    assign mult_multiplicand = op_b_q;
    assign out_valid         = out_valid_q;
    assign out_product       = out_product_q;
`ifdef SEQ_TIMEOUT_EN
    assign out_error         = out_error_q;
`else
    assign out_error         = 1'b0;
`endif
    assign busy = (state_q != S_IDLE) || (count_q != '0) || out_valid_q;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer. It uses a behavioural multiplier
// whose done latency and stale-done behaviour are set per test.
module tb_mult_job_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_multiplier;
    logic [7:0]  in_multiplicand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_error;
    logic        mult_rst;
    logic [7:0]  mult_multiplier;
    logic [7:0]  mult_multiplicand;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    mult_job_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_multiplier     (in_multiplier),
        .in_multiplicand   (in_multiplicand),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_product       (out_product),
        .out_error         (out_error),
        .mult_rst          (mult_rst),
        .mult_multiplier   (mult_multiplier),
        .mult_multiplicand (mult_multiplicand),
        .mult_done         (mult_done),
        .mult_product      (mult_product),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: its cycle count restarts on mult_rst, and the
    // product appears after lat cycles. When stale is set, done is forced
    // high from the start. When dead is set, done never comes.
    int          lat   = 10;
    bit          stale = 1'b0;
    bit          dead  = 1'b0;
    logic [15:0] mcnt;
    logic signed [15:0] sa, sb, sp;

    always @(posedge clk) begin
        if (mult_rst) mcnt <= '0;
        else if (mcnt != 16'hFFFF) mcnt <= mcnt + 16'd1;
    end

    assign sa           = {{8{mult_multiplier[7]}}, mult_multiplier};
    assign sb           = {{8{mult_multiplicand[7]}}, mult_multiplicand};
    assign sp           = sa * sb;
    assign mult_product = (mcnt >= 16'(lat)) ? sp : 16'hBAD0;
    assign mult_done    = !dead && (stale || (mcnt >= 16'(lat)));

    // Event monitor on the falling edge: counts restart pulses and result arrivals
    int cyc         = 0;
    int rst_pulses  = 0;
    int ov_rises    = 0;
    int last_rst_cyc = 0;
    int last_ov_cyc  = 0;
    bit prev_rst    = 1'b0;
    bit prev_ov     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mult_rst && !prev_rst) begin
            rst_pulses++;
            last_rst_cyc = cyc;
        end
        prev_rst = mult_rst;
        if (out_valid && !prev_ov) begin
            ov_rises++;
            last_ov_cyc = cyc;
        end
        prev_ov = out_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offer one operand pair until it is accepted; keep leaves in_valid high for a following push
    task automatic push(input logic [7:0] a, input logic [7:0] b, input bit keep);
        bit acc;
        acc             = 1'b0;
        in_valid        = 1'b1;
        in_multiplier   = a;
        in_multiplicand = b;
        for (int i = 0; i < 400 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        if (!keep) in_valid = 1'b0;
        check("push_accept", 32'(acc), 32'd1);
    endtask

    // Wait for a result, capture it and let it be consumed (out_ready assumed high)
    task automatic wait_result(input int budget, output logic [15:0] prod, output logic err);
        bit ok;
        ok   = 1'b0;
        prod = 'x;
        err  = 'x;
        for (int i = 0; i < budget && !ok; i++) begin
            if (out_valid) begin
                prod = out_product;
                err  = out_error;
                ok   = 1'b1;
            end
            tick();
        end
        check("result_arrive", 32'(ok), 32'd1);
    endtask

    logic [15:0] bp_exp [6] = '{16'h0002, 16'hFFFF, 16'h0064, 16'h001E, 16'hC080, 16'hFFCF};
    logic [7:0]  bp_a   [6] = '{8'd1, 8'hFF, 8'd10, 8'hFB, 8'd127, 8'd7};
    logic [7:0]  bp_b   [6] = '{8'd2, 8'd1, 8'd10, 8'hFA, 8'h80, 8'hF9};

    initial begin
        logic [15:0] prod;
        logic        err;
        int          p0, o0, got_n;

        reset           = 1'b1;
        in_valid        = 1'b0;
        in_multiplier   = '0;
        in_multiplicand = '0;
        out_ready       = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product",   32'(out_product), 32'd0);
        check("rst_error",     32'(out_error), 32'd0);
        check("rst_mult_rst",  32'(mult_rst), 32'd1);
        check("rst_mult_a",    32'(mult_multiplier), 32'd0);
        check("rst_mult_b",    32'(mult_multiplicand), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Single job (3, 5)
        lat = 10;
        p0  = rst_pulses;
        push(8'd3, 8'd5, 1'b0);
        wait_result(200, prod, err);
        check("single_product", 32'(prod), 32'h000F);
        check("single_error",   32'(err), 32'd0);
        check("single_latency", 32'(last_ov_cyc - last_rst_cyc), 32'd35);
        repeat (3) tick();
        check("single_busy",    32'(busy), 32'd0);
        check("single_pulses",  32'(rst_pulses - p0), 32'd1);

        // Signed operands, done arriving after the blanking window
        lat = 40;
        push(8'hFE, 8'h07, 1'b0);
        wait_result(200, prod, err);
        check("neg_pos_product", 32'(prod), 32'hFFF2);
        push(8'h80, 8'h80, 1'b0);
        wait_result(200, prod, err);
        check("min_min_product", 32'(prod), 32'h4000);

        // Stale done: high from launch, must be blanked for MIN_WAIT cycles
        lat   = 5;
        stale = 1'b1;
        push(8'h04, 8'hFD, 1'b0);
        wait_result(200, prod, err);
        check("stale_product", 32'(prod), 32'hFFF4);
        check("stale_latency", 32'(last_ov_cyc - last_rst_cyc), 32'd35);
        stale = 1'b0;
        repeat (3) tick();

        // Backpressure: six jobs with out_ready low
        lat       = 10;
        out_ready = 1'b0;
        p0        = rst_pulses;
        for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i], 1'b1);
        check("bp_full", 32'(in_ready), 32'd0);
        push(bp_a[5], bp_b[5], 1'b0);
        repeat (100) tick();
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_held_prod", 32'(out_product), 32'h0002);
        check("bp_hold_a",    32'(mult_multiplier), 32'h000000FF);
        check("bp_hold_b",    32'(mult_multiplicand), 32'h00000001);
        check("bp_full_again", 32'(in_ready), 32'd0);
        check("bp_busy",      32'(busy), 32'd1);
        check("bp_pulses",    32'(rst_pulses - p0), 32'd2);
        out_ready = 1'b1;
        got_n     = 0;
        for (int i = 0; i < 2000 && got_n < 6; i++) begin
            if (out_valid) begin
                check($sformatf("bp_order%0d", got_n), 32'(out_product), 32'(bp_exp[got_n]));
                got_n++;
            end
            tick();
        end
        check("bp_count", 32'(got_n), 32'd6);
        repeat (3) tick();

        // Reset mid-job with two jobs queued
        p0 = rst_pulses;
        push(8'd9, 8'd9, 1'b1);
        push(8'd8, 8'd8, 1'b1);
        push(8'd6, 8'd6, 1'b0);
        for (int i = 0; i < 50 && (rst_pulses == p0 || mult_rst); i++) tick();
        check("mid_launched", 32'(rst_pulses - p0), 32'd1);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check("mid_mult_rst",  32'(mult_rst), 32'd1);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_in_ready",  32'(in_ready), 32'd1);
        check("mid_busy",      32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        p0 = rst_pulses;
        o0 = ov_rises;
        repeat (150) tick();
        check("mid_no_result", 32'(ov_rises - o0), 32'd0);
        check("mid_no_launch", 32'(rst_pulses - p0), 32'd0);
        check("mid_idle",      32'(busy), 32'd0);

`ifdef SEQ_TIMEOUT_EN
        // Watchdog: a job whose done never comes returns an error result
        lat  = 10;
        dead = 1'b1;
        push(8'd2, 8'd3, 1'b1);
        push(8'd3, 8'd3, 1'b0);
        wait_result(600, prod, err);
        check("to_product", 32'(prod), 32'd0);
        check("to_error",   32'(err), 32'd1);
        dead = 1'b0;
        wait_result(200, prod, err);
        check("to_next_product", 32'(prod), 32'h0009);
        check("to_next_error",   32'(err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
